// File: rtl/tile_palette_arbiter_pkg.sv
// Shared graphics constants for the tile palette arbiter: requester count,
// palette geometry and the power-on palette table.
package tile_palette_arbiter_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int PAL_DEPTH = 16;
   localparam int IDX_W     = 4;
   localparam int COL_W     = 4;
   localparam int RGB_W     = 3 * COL_W;
   localparam int ID_W      = 2;

   localparam logic [RGB_W-1:0] PAL_BLUE  = 12'h00F;
   localparam logic [RGB_W-1:0] PAL_GREEN = 12'h0F0;

   // Default contents: entry 1 is blue, everything else green.
   function automatic logic [RGB_W-1:0] pal_default(input int idx);
      return (idx == 1) ? PAL_BLUE : PAL_GREEN;
   endfunction

endpackage

// File: rtl/tile_palette_arbiter_rr_select.sv
// Round-robin selector: first valid requester at or above the pointer,
// wrapping modulo N. Produces a one-hot grant plus an any-grant flag.
module rr_select #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  valid_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic          any_o
);

   // Scan N positions starting at ptr_i; the first hit wins.
   always_comb begin
      int  idx;
      logic found;
      idx     = 0;
      found   = 1'b0;
      grant_o = '0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (!found && valid_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/tile_palette_arbiter.sv
// Tile palette arbiter: N_REQ pixel requesters share one 16-entry palette.
// One grant per cycle, round-robin, into a single registered output stage.
module tile_palette_arbiter
   import tile_palette_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0][IDX_W-1:0] req_index,
   output logic [N_REQ-1:0]            req_ready,
   output logic                        out_valid,
   output logic [ID_W-1:0]             out_id,
   output logic [COL_W-1:0]            out_red,
   output logic [COL_W-1:0]            out_green,
   output logic [COL_W-1:0]            out_blue,
   input  logic                        out_ready,
   input  logic                        cfg_we,
   input  logic [IDX_W-1:0]            cfg_addr,
   input  logic [RGB_W-1:0]            cfg_rgb
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [RGB_W-1:0] pal_q [PAL_DEPTH];
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
   logic             out_valid_q;
   logic [ID_W-1:0]  out_id_q;
   logic [RGB_W-1:0] out_rgb_q;

   logic             stage_free;
   logic [N_REQ-1:0] cand;
   logic [N_REQ-1:0] grant;
   logic             any_grant;
   logic [PW-1:0]    gidx;

   // Stage can take a new result when empty or draining this cycle;
   // nothing is granted while Reset is asserted.
   assign stage_free = !out_valid_q || out_ready;
   assign cand       = (stage_free && !Reset) ? req_valid : '0;

   rr_select #(.N(N_REQ), .PW(PW)) u_rr_select (
      .valid_i (cand),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant),
      .any_o   (any_grant)
   );

   assign req_ready = grant;

   // Encode the one-hot grant into the grantee number.
   always_comb begin
      gidx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant[i]) gidx = PW'(i);
   end

   // Pointer moves just past the grantee; holds when idle.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (any_grant)
         rr_ptr_d = (int'(gidx) == N_REQ - 1) ? '0 : gidx + PW'(1);
   end

   // Palette storage; reads this cycle see the value before any write.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int e = 0; e < PAL_DEPTH; e++) pal_q[e] <= pal_default(e);
      end else if (cfg_we) begin
         pal_q[cfg_addr] <= cfg_rgb;
      end
   end

   // Output stage and round-robin pointer; a held result is dropped on Reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_rgb_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (any_grant) begin
            out_valid_q <= 1'b1;
            out_id_q    <= ID_W'(gidx);
            out_rgb_q   <= pal_q[req_index[gidx]];
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_rgb_q   <= '0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_id    = out_valid_q ? out_id_q : '0;
   assign out_red   = out_valid_q ? out_rgb_q[RGB_W-1 -: COL_W]   : '0;
   assign out_green = out_valid_q ? out_rgb_q[2*COL_W-1 -: COL_W] : '0;
   assign out_blue  = out_valid_q ? out_rgb_q[COL_W-1:0]          : '0;

endmodule
